// File: rtl/risc_pkg.sv
// Shared types and constants for the IITB-RISC front end.
//   word_t         16-bit instruction word / word address
//   fetch_state_e  fetch controller state (run, drain before halt, halted)
//   redir_src_e    which pipeline stage supplied the winning redirect
//   HaltWord       default end-of-program instruction encoding
package risc_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StHalt  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    SrcNone = 2'd0,
    SrcId   = 2'd1,
    SrcRr   = 2'd2,
    SrcEx   = 2'd3
  } redir_src_e;

  localparam word_t HaltWord = 16'hFFFF;

endpackage

// File: rtl/redirect_sel.sv
// Combinational redirect arbiter for the fetch controller.
// The oldest resolving instruction wins: EX (BEQ) > RR (JLR) > ID (JAL).
// Ports:
//   enable               0 suppresses every redirect and flush (fetch halted)
//   id/rr/ex_redir       redirect requests from ID, RR and EX
//   id/rr/ex_target      corresponding target addresses
//   taken                a redirect won this cycle
//   target               address of the winning redirect
//   source               stage that supplied the winning redirect
//   flush_id/rr/ex       kill the younger pipeline registers behind the winner
module redirect_sel
  import risc_pkg::*;
(
  input  logic       enable,
  input  logic       id_redir,
  input  word_t      id_target,
  input  logic       rr_redir,
  input  word_t      rr_target,
  input  logic       ex_redir,
  input  word_t      ex_target,
  output logic       taken,
  output word_t      target,
  output redir_src_e source,
  output logic       flush_id,
  output logic       flush_rr,
  output logic       flush_ex
);

  always_comb begin
    taken    = 1'b0;
    target   = '0;
    source   = SrcNone;
    flush_id = 1'b0;
    flush_rr = 1'b0;
    flush_ex = 1'b0;
    if (enable) begin
      if (ex_redir) begin
        taken    = 1'b1;
        target   = ex_target;
        source   = SrcEx;
        flush_id = 1'b1;
        flush_rr = 1'b1;
        flush_ex = 1'b1;
      end else if (rr_redir) begin
        taken    = 1'b1;
        target   = rr_target;
        source   = SrcRr;
        flush_id = 1'b1;
        flush_rr = 1'b1;
      end else if (id_redir) begin
        taken    = 1'b1;
        target   = id_target;
        source   = SrcId;
        flush_id = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the combinational ROM
// address, registers fetched words into IF/ID, applies redirects over stalls
// and sequences halt on the end-of-program word.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   imem_addr/data      ROM address (= PC) and combinational read data
//   stall               hold PC and IF/ID (overridden by any redirect)
//   *_redir/*_target    JAL (ID), JLR (RR), taken-BEQ (EX) redirects
//   ifid_*              IF/ID register: valid, instruction, its PC, PC+1
//   flush_id/rr/ex      flush lines from the winning redirect
//   halted              fetch permanently stopped until reset
module fetch_ctrl
  import risc_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = HaltWord,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        id_redir,
  input  logic [15:0] id_target,
  input  logic        rr_redir,
  input  logic [15:0] rr_target,
  input  logic        ex_redir,
  input  logic [15:0] ex_target,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic [15:0] ifid_pc1,
  output logic        flush_id,
  output logic        flush_rr,
  output logic        flush_ex,
  output logic        halted
);

  localparam int unsigned CntW = 8;

  fetch_state_e   state_q, state_d;
  word_t          pc_q, pc_d;
  logic           valid_q, valid_d;
  word_t          instr_q, instr_d;
  word_t          ipc_q, ipc_d;
  word_t          ipc1_q, ipc1_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic       redir_taken;
  word_t      redir_target;
  redir_src_e redir_source;

  redirect_sel u_redirect_sel (
    .enable    (state_q != StHalt),
    .id_redir  (id_redir),
    .id_target (id_target),
    .rr_redir  (rr_redir),
    .rr_target (rr_target),
    .ex_redir  (ex_redir),
    .ex_target (ex_target),
    .taken     (redir_taken),
    .target    (redir_target),
    .source    (redir_source),
    .flush_id  (flush_id),
    .flush_rr  (flush_rr),
    .flush_ex  (flush_ex)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc1_d  = ipc1_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (redir_taken) begin
          pc_d    = redir_target;
          valid_d = 1'b0;
        end else if (stall) begin
          // hold everything
        end else if (imem_data == HALT_WORD) begin
          // PC parks on the halt word; a later redirect may still cancel it
          valid_d = 1'b0;
          cnt_d   = CntW'(DRAIN_CYC);
          state_d = StDrain;
        end else begin
          valid_d = 1'b1;
          instr_d = imem_data;
          ipc_d   = pc_q;
          ipc1_d  = pc_q + 16'd1;
          pc_d    = pc_q + 16'd1;
        end
      end
      StDrain: begin
        valid_d = 1'b0;
        if (redir_taken) begin
          pc_d    = redir_target;
          cnt_d   = '0;
          state_d = StRun;
        end else if (!stall) begin
          if (cnt_q <= CntW'(1)) begin
            cnt_d   = '0;
            state_d = StHalt;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StHalt: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      ipc1_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc1_q  <= ipc1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr  = pc_q;
  assign ifid_valid = valid_q;
  assign ifid_instr = instr_q;
  assign ifid_pc    = ipc_q;
  assign ifid_pc1   = ipc1_q;
  assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by random stimulus, all
// checked every cycle against a cycle-level reference model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        id_redir = 1'b0, rr_redir = 1'b0, ex_redir = 1'b0;
  logic [15:0] id_target = '0, rr_target = '0, ex_target = '0;
  logic        ifid_valid;
  logic [15:0] ifid_instr, ifid_pc, ifid_pc1;
  logic        flush_id, flush_rr, flush_ex;
  logic        halted;

  logic [15:0] rom [65536];

  assign imem_data = rom[imem_addr];

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .stall      (stall),
    .id_redir   (id_redir),
    .id_target  (id_target),
    .rr_redir   (rr_redir),
    .rr_target  (rr_target),
    .ex_redir   (ex_redir),
    .ex_target  (ex_target),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_pc1   (ifid_pc1),
    .flush_id   (flush_id),
    .flush_rr   (flush_rr),
    .flush_ex   (flush_ex),
    .halted     (halted)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: architectural view of the fetch unit.
  bit          m_known = 0;
  logic [15:0] m_pc;
  bit          m_v;
  logic [15:0] m_instr, m_ipc, m_ipc1;
  bit          m_halted;
  int          m_drain_left;  // -1 when no halt word is pending

  task automatic step(input bit r, input bit s,
                      input bit ir, input logic [15:0] it,
                      input bit rr, input logic [15:0] rt,
                      input bit er, input logic [15:0] et);
    bit          w_taken;
    logic [15:0] w_tgt;
    int          n_flush;
    rst = r; stall = s;
    id_redir = ir; id_target = it;
    rr_redir = rr; rr_target = rt;
    ex_redir = er; ex_target = et;
    #1;
    // oldest instruction wins: count how many stages are killed
    n_flush = er ? 3 : rr ? 2 : ir ? 1 : 0;
    w_tgt   = er ? et : rr ? rt : it;
    if (m_halted) n_flush = 0;
    w_taken = (n_flush != 0);
    if (m_known) begin
      check_eq("imem_addr", imem_addr, m_pc);
      check_eq("ifid_valid", ifid_valid, m_v);
      check_eq("ifid_instr", ifid_instr, m_instr);
      check_eq("ifid_pc", ifid_pc, m_ipc);
      check_eq("ifid_pc1", ifid_pc1, m_ipc1);
      check_eq("halted", halted, m_halted);
      check_eq("flush_id", flush_id, n_flush >= 1);
      check_eq("flush_rr", flush_rr, n_flush >= 2);
      check_eq("flush_ex", flush_ex, n_flush >= 3);
    end
    if (r) begin
      m_known = 1; m_pc = 16'h0000; m_v = 0;
      m_instr = 0; m_ipc = 0; m_ipc1 = 0;
      m_halted = 0; m_drain_left = -1;
    end else if (m_known && !m_halted) begin
      if (w_taken) begin
        m_pc = w_tgt; m_v = 0; m_drain_left = -1;
      end else if (m_drain_left >= 0) begin
        if (!s) begin
          m_drain_left--;
          if (m_drain_left <= 0) begin
            m_halted = 1; m_drain_left = -1;
          end
        end
      end else if (!s) begin
        if (rom[m_pc] == 16'hFFFF) begin
          m_v = 0; m_drain_left = 3;
        end else begin
          m_v = 1; m_instr = rom[m_pc]; m_ipc = m_pc;
          m_ipc1 = 16'(m_pc + 1); m_pc = 16'(m_pc + 1);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 16'(i) ^ 16'h1000;
    rom[3] = 16'hFFFF;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_pc", imem_addr, 16'h0000);
    check_eq("rst_valid", ifid_valid, 0);
    check_eq("rst_halted", halted, 0);

    // Straight line into the halt word at 3
    idle(1);
    check_eq("sl_pc0", ifid_pc, 16'h0000);
    check_eq("sl_pc1_0", ifid_pc1, 16'h0001);
    idle(2);
    check_eq("sl_pc2", ifid_pc, 16'h0002);
    check_eq("sl_pc1_2", ifid_pc1, 16'h0003);
    idle(1);  // halt word fetched
    check_eq("sl_valid_drop", ifid_valid, 0);
    idle(2);
    check_eq("sl_not_yet", halted, 0);
    idle(1);
    check_eq("sl_halted", halted, 1);
    check_eq("sl_pc_hold", imem_addr, 16'h0003);
    step(0, 1, 1, 16'h0040, 0, 0, 1, 16'h0050);  // ignored in halt
    check_eq("halt_frozen", imem_addr, 16'h0003);

    // Reset out of halt
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rh_pc", imem_addr, 16'h0000);
    check_eq("rh_halted", halted, 0);
    check_eq("rh_valid", ifid_valid, 0);

    // Stall at PC 5
    rom[3] = 16'h0003;
    idle(5);
    check_eq("st_at5", imem_addr, 16'h0005);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check_eq("st_hold_pc", imem_addr, 16'h0005);
    check_eq("st_hold_ifid", ifid_pc, 16'h0004);
    idle(1);
    check_eq("st_resume_ifid", ifid_pc, 16'h0005);
    check_eq("st_resume_pc", imem_addr, 16'h0006);

    // Redirect priority
    id_redir = 1; id_target = 16'h0041;
    rr_redir = 1; rr_target = 16'h001B;
    ex_redir = 1; ex_target = 16'h002F;
    #1;
    check_eq("pri_flush", {flush_id, flush_rr, flush_ex}, 3'b111);
    step(0, 0, 1, 16'h0041, 1, 16'h001B, 1, 16'h002F);
    check_eq("pri_pc", imem_addr, 16'h002F);
    check_eq("pri_valid", ifid_valid, 0);

    // Halt cancel
    rom[4] = 16'hFFFF;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    idle(1);  // FFFF fetched at 4
    step(0, 0, 0, 0, 0, 0, 1, 16'h0002);
    check_eq("hc_pc", imem_addr, 16'h0002);
    idle(1);
    check_eq("hc_halted", halted, 0);
    check_eq("hc_valid", ifid_valid, 1);
    check_eq("hc_ifid_pc", ifid_pc, 16'h0002);
    rom[4] = 16'h0004;

    // Redirect over stall, then wrap
    step(0, 1, 0, 0, 1, 16'hFFFF, 0, 0);
    check_eq("wr_pc", imem_addr, 16'hFFFF);
    idle(1);
    check_eq("wr_ifid_pc", ifid_pc, 16'hFFFF);
    check_eq("wr_ifid_pc1", ifid_pc1, 16'h0000);
    check_eq("wr_pc_wrap", imem_addr, 16'h0000);

    // Random phase
    for (int i = 0; i < 65536; i++)
      rom[i] = ($urandom % 10 == 0) ? 16'hFFFF : 16'($urandom & 32'h7FFF);
    for (int c = 0; c < 4000; c++) begin
      bit          r, s, ir, rr, er;
      logic [15:0] t0, t1, t2;
      r  = ($urandom % 300 == 0) || (m_halted && $urandom % 6 == 0);
      s  = ($urandom % 4 == 0);
      ir = ($urandom % 12 == 0);
      rr = ($urandom % 16 == 0);
      er = ($urandom % 20 == 0);
      t0 = ($urandom % 8 == 0) ? 16'(16'hFFF0 + $urandom % 16) : 16'($urandom % 64);
      t1 = 16'($urandom % 64);
      t2 = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom % 64);
      step(r, s, ir, t0, rr, t1, er, t2);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the six-stage IITB-RISC pipeline (IF, ID, RR, EX, MM, WB). Owns the program counter and drives the address of the combinational instruction ROM. Registers the fetched word into the IF/ID pipeline register. Arbitrates redirects from JAL (ID), JLR (RR) and BEQ (EX) against hazard stalls, emits per-stage flushes, and sequences halt on the 16'hFFFF end-of-program word.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- HALT_WORD, 16'hFFFF, instruction encoding that ends fetch
- DRAIN_CYC, 3, unstalled cycles waited after halt fetch before committing halt (ID/RR/EX resolution depth)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  16  ROM address; equals PC register directly (no extra cycle)
- imem_data  in  16  ROM read data, combinational from imem_addr
- stall  in  1  hazard unit request to hold PC and IF/ID
- id_redir / id_target  in  1 / 16  JAL redirect from ID
- rr_redir / rr_target  in  1 / 16  JLR redirect from RR
- ex_redir / ex_target  in  1 / 16  taken-BEQ redirect from EX
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_instr  out  16  fetched instruction
- ifid_pc  out  16  address of ifid_instr
- ifid_pc1  out  16  ifid_pc + 1 (JAL/JLR link value)
- flush_id / flush_rr / flush_ex  out  1  kill the ID / RR / EX pipeline register contents at next edge
- halted  out  1  fetch permanently stopped

## Operation
- PC is a word address. Next PC is PC+1, modulo 2^16: 16'hFFFF wraps to 16'h0000.
- Redirect priority: ex_redir > rr_redir > id_redir. The oldest instruction wins. Any redirect beats stall.
- Flushes are combinational from the winning redirect:
  - ex_redir: flush_id=flush_rr=flush_ex=1
  - rr_redir: flush_id=flush_rr=1
  - id_redir: flush_id=1
- States:
  - RUN: normal fetch.
  - DRAIN: halt word seen; waiting for older instructions to resolve.
  - HALT: terminal.
- RUN:
  - Redirect: PC <= target; ifid_valid <= 0.
  - Else stall: PC and IF/ID hold.
  - Else if imem_data == HALT_WORD: PC holds; ifid_valid <= 0; load drain counter with DRAIN_CYC; state -> DRAIN.
  - Else: IF/ID <= {1, imem_data, PC, PC+1}; PC <= PC+1.
- DRAIN:
  - No fetch; ifid_valid = 0.
  - Redirect: PC <= target; state -> RUN. The halt is cancelled because it was on the wrong path.
  - Stall without redirect: counter holds.
  - Otherwise the counter decrements. When it reaches 0: state -> HALT, halted <= 1.
- HALT: PC frozen, ifid_valid=0, redirects and stall ignored, flushes 0. Only rst exits.

## Timing
- Reset values: PC=RESET_PC, imem_addr=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc1=0, halted=0, state RUN, drain counter 0.
- Fetch latency: an instruction at address A presented in cycle n appears in IF/ID after edge n.
- Redirect penalty: the target instruction appears in IF/ID two edges after the redirect cycle.
  - Bubbles inserted: ID redirect 1, RR redirect 2, EX redirect 3 (counting flushed stages).
- Simultaneous redirect and stall: redirect taken, stall ignored for fetch. The stalled younger stages are flushed.
- Simultaneous redirects: only the highest-priority target is used.
- Halt word under stall: not consumed until stall drops.
- rst mid-DRAIN or in HALT: returns to RUN at RESET_PC next cycle.
- halted rises on the edge after the DRAIN_CYC-th unstalled drain cycle.

## Structure
- Shared package `risc_pkg`:
  - fetch state enum (RUN, DRAIN, HALT)
  - HALT_WORD constant
  - 16-bit word/address typedef
  - redirect-source encoding (NONE, ID, RR, EX)
- One sub-module `redirect_sel`: combinational priority selector producing {taken, target, source} and the three flush lines. The PC/IF-ID registers and the FSM stay in fetch_ctrl.

## Test plan
- Straight line:
  - Stimulus: ROM[0..2] = adi words, ROM[3] = FFFF, no stall, no redirect.
  - Response: IF/ID shows PC 0, 1, 2 on consecutive edges with ifid_pc1 = 1, 2, 3. ifid_valid drops when FFFF is fetched. halted=1 exactly 3 edges after the FFFF fetch cycle. PC stays 3.
- Stall:
  - Stimulus: assert stall for 2 cycles while PC=5.
  - Response: imem_addr stays 5; IF/ID holds its previous contents. Fetch resumes with PC 5 -> 6.
- Redirect priority:
  - Stimulus: in one cycle, id_redir→16'h0041, rr_redir→16'h001B, ex_redir→16'h002F.
  - Response: flush_id=flush_rr=flush_ex=1; next PC=16'h002F; ifid_valid=0 for that edge.
- Halt cancel:
  - Stimulus: FFFF fetched at PC 4; in the following cycle ex_redir→16'h0002.
  - Response: state back to RUN; PC=2; halted stays 0; the instruction at 2 is valid in IF/ID two edges after the redirect.
- Redirect over stall, plus wrap:
  - Stimulus: stall=1 together with rr_redir→16'hFFFF.
  - Response: PC=FFFF. On the next unstalled cycle ifid_pc=FFFF and ifid_pc1=0000, and PC wraps to 0000.
- Reset:
  - Stimulus: assert rst while in HALT.
  - Response: next edge gives PC=0, halted=0, ifid_valid=0.
